// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the SDF FFT pipeline stages.
//   PH_FILL / PH_BFLY / PH_TWID : stage phase encoding reported on 'state'.
//   tw_entry()                  : rounded fixed-point twiddle table entry,
//                                 intended for elaboration-time use only.
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam logic [1:0] PH_FILL = 2'd0;
  localparam logic [1:0] PH_BFLY = 2'd1;
  localparam logic [1:0] PH_TWID = 2'd2;

  localparam real TW_PI = 3.14159265358979323846;

  // Round half away from zero.
  function automatic int tw_round(input real x);
    if (x >= 0.0) begin
      return $rtoi(x + 0.5);
    end else begin
      return -$rtoi(0.5 - x);
    end
  endfunction

  // Entry k of W_{2*half}^k scaled by 2^frac.
  //   want_im = 0 : round(2^frac * cos(pi*k/half))
  //   want_im = 1 : -round(2^frac * sin(pi*k/half))
  function automatic int tw_entry(input int k, input int half, input int frac,
                                  input bit want_im);
    real ang;
    real scale;
    ang   = (TW_PI * real'(k)) / real'(half);
    scale = real'(32'sd1 << frac);
    if (want_im) begin
      return -tw_round(scale * $sin(ang));
    end else begin
      return tw_round(scale * $cos(ang));
    end
  endfunction

endpackage

// File: rtl/sdf_twiddle_table.sv
// -----------------------------------------------------------------------------
// sdf_twiddle_table
// Combinational twiddle ROM for one radix-2 SDF stage. Contents are fixed at
// elaboration from fft_pkg::tw_entry; no clock.
// Ports:
//   k   in  $clog2(HALF)  twiddle index within the TWID phase
//   re  out W             real part, two's complement, FRAC fractional bits
//   im  out W             imaginary part (already negated sine)
// -----------------------------------------------------------------------------
module sdf_twiddle_table
  import fft_pkg::*;
#(
  parameter int HALF = 16,
  parameter int W    = 24,
  parameter int FRAC = 8,
  parameter int KW   = $clog2(HALF)
) (
  input  logic [KW-1:0] k,
  output logic [W-1:0]  re,
  output logic [W-1:0]  im
);

  logic [W-1:0] rom_re_s [HALF];
  logic [W-1:0] rom_im_s [HALF];

  for (genvar i = 0; i < HALF; i++) begin : g_rom
    localparam int RE_I = tw_entry(i, HALF, FRAC, 1'b0);
    localparam int IM_I = tw_entry(i, HALF, FRAC, 1'b1);
    // The int casts sign-extend (or narrow) to the twiddle word width.
    assign rom_re_s[i] = W'(RE_I);
    assign rom_im_s[i] = W'(IM_I);
  end

  // ROM read port.
  always_comb begin
    re = rom_re_s[k];
    im = rom_im_s[k];
  end

endmodule

// File: rtl/sdf_twiddle_gen.sv
// -----------------------------------------------------------------------------
// sdf_twiddle_gen
// Phase tracker and twiddle generator for one radix-2 SDF FFT stage.
// Optional feature macro: TWIDDLE_INVERSE_EN (adds 'inv' for IFFT conjugate
// twiddles). Without it the block produces forward twiddles only.
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   a sample is presented this cycle
//   inv        in   (TWIDDLE_INVERSE_EN only) negate w_i in TWID
//   state      out  0 FILL, 1 BFLY, 2 TWID
//   w_r, w_i   out  twiddle real / imaginary, W bits, FRAC fractional bits
//   tw_valid   out  state/w_r/w_i describe a live sample
//   phase_last out  current index is the last of its phase
//   frame_done out  pulse on the advancing last TWID sample
// All outputs decode the registered index/phase/drain with no added latency.
// -----------------------------------------------------------------------------
module sdf_twiddle_gen
  import fft_pkg::*;
#(
  parameter int HALF = 16,
  parameter int W    = 24,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
`ifdef TWIDDLE_INVERSE_EN
  input  logic         inv,
`endif
  output logic [1:0]   state,
  output logic [W-1:0] w_r,
  output logic [W-1:0] w_i,
  output logic         tw_valid,
  output logic         phase_last,
  output logic         frame_done
);

  localparam int            KW      = $clog2(HALF);
  localparam logic [KW-1:0] K_LAST  = KW'(HALF - 1);
  localparam int            UNITY_I = 32'sd1 << FRAC;
  localparam logic [W-1:0]  UNITY   = W'(UNITY_I);

  logic [KW-1:0] k_q, k_d;
  logic [1:0]    ph_q, ph_d;
  logic          drain_q, drain_d;
  logic          adv_s;
  logic          wrap_s;
  logic          inv_s;
  logic [W-1:0]  tbl_re_s;
  logic [W-1:0]  tbl_im_s;

`ifdef TWIDDLE_INVERSE_EN
  assign inv_s = inv;
`else
  assign inv_s = 1'b0;
`endif

  sdf_twiddle_table #(
    .HALF (HALF),
    .W    (W),
    .FRAC (FRAC),
    .KW   (KW)
  ) u_table (
    .k  (k_q),
    .re (tbl_re_s),
    .im (tbl_im_s)
  );

  // State register: index, phase and drain flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= {KW{1'b0}};
      ph_q    <= PH_FILL;
      drain_q <= 1'b0;
    end else begin
      k_q     <= k_d;
      ph_q    <= ph_d;
      drain_q <= drain_d;
    end
  end

  // Next-state: index advance, phase sequencing and drain control.
  always_comb begin
    // A drained TWID keeps stepping without input so the delay line flushes.
    adv_s   = in_valid | drain_q;
    wrap_s  = adv_s & (k_q == K_LAST);
    k_d     = k_q;
    ph_d    = ph_q;
    drain_d = drain_q;
    if (adv_s) begin
      k_d = k_q + KW'(1);
    end else begin
      k_d = k_q;
    end
    case (ph_q)
      PH_FILL: begin
        drain_d = 1'b0;
        if (wrap_s) begin
          ph_d = PH_BFLY;
        end else begin
          ph_d = PH_FILL;
        end
      end
      PH_BFLY: begin
        drain_d = 1'b0;
        if (wrap_s) begin
          ph_d = PH_TWID;
        end else begin
          ph_d = PH_BFLY;
        end
      end
      PH_TWID: begin
        if (wrap_s) begin
          ph_d    = PH_BFLY;
          drain_d = 1'b0;
        end else if (!in_valid) begin
          // Input gap inside TWID: start (or continue) draining.
          ph_d    = PH_TWID;
          drain_d = 1'b1;
        end else begin
          ph_d    = PH_TWID;
          drain_d = drain_q;
        end
      end
      default: begin
        ph_d    = PH_FILL;
        drain_d = 1'b0;
      end
    endcase
  end

  // Output decode of the current sample.
  always_comb begin
    state      = ph_q;
    tw_valid   = (in_valid | drain_q) & (ph_q != PH_FILL);
    phase_last = (k_q == K_LAST);
    frame_done = (ph_q == PH_TWID) & wrap_s;
    if (ph_q == PH_TWID) begin
      w_r = tbl_re_s;
      if (inv_s) begin
        w_i = -tbl_im_s;
      end else begin
        w_i = tbl_im_s;
      end
    end else begin
      // FILL and BFLY pass samples with a unity twiddle.
      w_r = UNITY;
      w_i = {W{1'b0}};
    end
  end

endmodule

// File: tb/tb_sdf_twiddle_gen.sv
// -----------------------------------------------------------------------------
// tb_sdf_twiddle_gen
// Directed bench for sdf_twiddle_gen with two instances (HALF=16 and HALF=2,
// W=24, FRAC=8) sharing clock, reset and in_valid. A sample-count model gives
// the expected outputs each cycle; literal values pin the model.
// Optional feature macro: TWIDDLE_INVERSE_EN.
// -----------------------------------------------------------------------------
module tb_sdf_twiddle_gen;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        inv = 1'b0;
  logic        chk_en = 1'b0;

  logic [1:0]  st16, st2;
  logic [23:0] wr16, wi16, wr2, wi2;
  logic        tv16, pl16, fd16, tv2, pl2, fd2;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: samples consumed since reset and drain flag, per instance.
  int p16 = 0;
  int p2  = 0;
  bit d16 = 1'b0;
  bit d2  = 1'b0;

  always #5 clk = ~clk;

  sdf_twiddle_gen #(.HALF(16), .W(24), .FRAC(8)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef TWIDDLE_INVERSE_EN
    .inv(inv),
`endif
    .state(st16), .w_r(wr16), .w_i(wi16),
    .tw_valid(tv16), .phase_last(pl16), .frame_done(fd16)
  );

  sdf_twiddle_gen #(.HALF(2), .W(24), .FRAC(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef TWIDDLE_INVERSE_EN
    .inv(inv),
`endif
    .state(st2), .w_r(wr2), .w_i(wi2),
    .tw_valid(tv2), .phase_last(pl2), .frame_done(fd2)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(0.5 - x);
  endfunction

  // Phase of the sample at position p: first half FILL, then BFLY/TWID alternate.
  function automatic int m_phase(input int p, input int half);
    if (p < half) return 0;
    return ((((p - half) / half) % 2) == 0) ? 1 : 2;
  endfunction

  task automatic m_step(input int half, inout int p, inout bit d);
    bit adv;
    int ph;
    if (rst) begin
      p = 0;
      d = 1'b0;
    end else begin
      adv = in_valid || d;
      ph  = m_phase(p, half);
      if (adv) begin
        if (ph == 2 && (p % half) == half - 1) d = 1'b0;
        p++;
      end else if (ph == 2) begin
        d = 1'b1;
      end
    end
  endtask

  task automatic cmp_dut(input string tag, input int half, input int p, input bit d,
                         input logic [1:0] st, input logic [23:0] wr, input logic [23:0] wi,
                         input logic tv, input logic pl, input logic fd);
    int  ph;
    int  k;
    bit  live;
    int  ewr;
    int  ewi;
    ph   = m_phase(p, half);
    k    = p % half;
    live = in_valid || d;
    if (ph == 2) begin
      ewr = rnd(256.0 * $cos(PI * real'(k) / real'(half)));
      ewi = -rnd(256.0 * $sin(PI * real'(k) / real'(half)));
      if (inv) ewi = -ewi;
    end else begin
      ewr = 256;
      ewi = 0;
    end
    chk({tag, ".state"},      int'(st), ph);
    chk({tag, ".w_r"},        int'($signed(wr)), ewr);
    chk({tag, ".w_i"},        int'($signed(wi)), ewi);
    chk({tag, ".tw_valid"},   int'(tv), int'(live && ph != 0));
    chk({tag, ".phase_last"}, int'(pl), int'(k == half - 1));
    chk({tag, ".frame_done"}, int'(fd), int'(live && ph == 2 && k == half - 1));
  endtask

  // Model advance on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    m_step(16, p16, d16);
    m_step(2, p2, d2);
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("h16", 16, p16, d16, st16, wr16, wi16, tv16, pl16, fd16);
      cmp_dut("h2",  2,  p2,  d2,  st2,  wr2,  wi2,  tv2,  pl2,  fd2);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset.
    tick;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst.state", int'(st16), 0);
    chk("rst.w_r", int'($signed(wr16)), 256);
    chk("rst.w_i", int'($signed(wi16)), 0);
    chk("rst.tw_valid", int'(tv16), 0);
    chk("rst.phase_last", int'(pl16), 0);
    chk("rst.frame_done", int'(fd16), 0);
    tick;
    rst = 1'b0;

    // Continuous stream: FILL 0..15, BFLY 16..31, TWID 32..47.
    for (int s = 0; s < 48; s++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (s == 5)  chk("fill.state", int'(st16), 0);
      if (s == 15) chk("fill_end.state", int'(st16), 0);
      if (s == 16) chk("bfly0.state", int'(st16), 1);
      if (s == 20) begin
        chk("bfly.w_r", int'($signed(wr16)), 256);
        chk("bfly.w_i", int'($signed(wi16)), 0);
      end
      if (s == 33) begin
        chk("twid1.w_r", int'($signed(wr16)), 251);
        chk("twid1.w_i", int'($signed(wi16)), -50);
      end
      if (s == 36) begin
        chk("twid4.w_r", int'($signed(wr16)), 181);
        chk("twid4.w_i", int'($signed(wi16)), -181);
      end
      if (s == 40) begin
        chk("twid8.w_r", int'($signed(wr16)), 0);
        chk("twid8.w_i", int'($signed(wi16)), -256);
      end
      if (s == 47) begin
        chk("twid15.w_r", int'($signed(wr16)), -251);
        chk("twid15.w_i", int'($signed(wi16)), -50);
        chk("twid15.frame_done", int'(fd16), 1);
      end
      if (s == 4) begin
        chk("h2.twid0.w_r", int'($signed(wr2)), 256);
        chk("h2.twid0.w_i", int'($signed(wi2)), 0);
      end
      if (s == 5) begin
        chk("h2.twid1.w_r", int'($signed(wr2)), 0);
        chk("h2.twid1.w_i", int'($signed(wi2)), -256);
        chk("h2.twid1.frame_done", int'(fd2), 1);
      end
      if (s == 7) chk("h2.bfly1.frame_done", int'(fd2), 0);
      if (s == 9) chk("h2.frame4.frame_done", int'(fd2), 1);
      tick;
    end

    // BFLY gap at k=7 for 5 cycles.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      tick;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
      chk("gap.tw_valid", int'(tv16), 0);
      chk("gap.state", int'(st16), 1);
      tick;
    end
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (i == 8) chk("gap_resume.phase_last", int'(pl16), 1);
      tick;
    end

    // TWID k=0..2 live, then input stops and the stage drains.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      tick;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_start.tw_valid", int'(tv16), 0);
    tick;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("drain.tw_valid", int'(tv16), 1);
      chk("drain.state", int'(st16), 2);
      chk("drain.frame_done", int'(fd16), (i == 12) ? 1 : 0);
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_drain.state", int'(st16), 1);
      chk("post_drain.tw_valid", int'(tv16), 0);
      chk("post_drain.phase_last", int'(pl16), 0);
      tick;
    end

    // BFLY then TWID with inv asserted where available.
`ifdef TWIDDLE_INVERSE_EN
    inv = 1'b1;
`endif
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (i == 4) begin
        chk("inv_bfly.w_r", int'($signed(wr16)), 256);
        chk("inv_bfly.w_i", int'($signed(wi16)), 0);
      end
      tick;
    end
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (i == 1) begin
        chk("twid1b.w_r", int'($signed(wr16)), 251);
`ifdef TWIDDLE_INVERSE_EN
        chk("inv_twid1.w_i", int'($signed(wi16)), 50);
`else
        chk("twid1b.w_i", int'($signed(wi16)), -50);
`endif
      end
      tick;
    end

    // Reset at TWID k=9.
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst.state", int'(st16), 2);
    tick;
    @(negedge clk);
    chk("mid_rst.state", int'(st16), 0);
    chk("mid_rst.w_r", int'($signed(wr16)), 256);
    chk("mid_rst.w_i", int'($signed(wi16)), 0);
    chk("mid_rst.tw_valid", int'(tv16), 0);
    tick;
    rst = 1'b0;
    inv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("refill.state", int'(st16), 0);
      tick;
    end
    @(negedge clk);
    chk("refill_done.state", int'(st16), 1);
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
